// File: rtl/mult_ctrl_if.sv
// Pipeline/multiplier-facing bundle for the HI/LO multiply controller.
interface mult_ctrl_if;
  logic        flush;
  logic        mult_en;
  logic        is_unsign;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_prod;
  logic        mult_busy;
  logic        mult_done;
  logic [31:0] hi;
  logic [31:0] lo;

  // Pipeline and combinational multiplier side
  modport master (
    output flush, mult_en, is_unsign, op_a, op_b, mthi, mtlo, wdata, mul_prod,
    input  mul_a, mul_b, mult_busy, mult_done, hi, lo
  );

  // Controller side
  modport slave (
    input  flush, mult_en, is_unsign, op_a, op_b, mthi, mtlo, wdata, mul_prod,
    output mul_a, mul_b, mult_busy, mult_done, hi, lo
  );
endinterface

// File: rtl/mult_ctrl.sv
// Multiply sequencer and HI/LO register file: holds operands for LATENCY
// cycles, samples the signed product, applies the MULTU correction and commits.
module mult_ctrl #(
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  mult_ctrl_if.slave bus
);
  localparam int unsigned DW    = 32;
  localparam int unsigned PW    = 64;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CORR = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [DW-1:0]    r_mul_a;
  logic [DW-1:0]    w_mul_a_nxt;
  logic [DW-1:0]    r_mul_b;
  logic [DW-1:0]    w_mul_b_nxt;
  logic             r_uns;
  logic             w_uns_nxt;
  logic [PW-1:0]    r_prod;
  logic [PW-1:0]    w_prod_nxt;
  logic [DW-1:0]    r_hi;
  logic [DW-1:0]    w_hi_nxt;
  logic [DW-1:0]    r_lo;
  logic [DW-1:0]    w_lo_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [PW-1:0]    w_corr_a;
  logic [PW-1:0]    w_corr_b;
  logic [PW-1:0]    w_corr;
  logic             w_busy;

  // Unsigned correction: a negative-looking operand under MULTU adds the other operand << 32
  assign w_corr_a = (r_uns & r_mul_a[DW-1]) ? {r_mul_b, DW'(0)} : PW'(0);
  assign w_corr_b = (r_uns & r_mul_b[DW-1]) ? {r_mul_a, DW'(0)} : PW'(0);
  assign w_corr   = r_prod + w_corr_a + w_corr_b;

  // Stall request, including the accepting IDLE cycle
  assign w_busy = ((r_state == S_IDLE) & bus.mult_en & ~bus.flush) |
                  (r_state == S_WAIT) | (r_state == S_CORR);

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_uns   <= 1'b0;
      r_prod  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mul_a <= w_mul_a_nxt;
      r_mul_b <= w_mul_b_nxt;
      r_uns   <= w_uns_nxt;
      r_prod  <= w_prod_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and next-register logic; flush overrides everything in any state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mul_a_nxt = r_mul_a;
    w_mul_b_nxt = r_mul_b;
    w_uns_nxt   = r_uns;
    w_prod_nxt  = r_prod;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_done_nxt  = 1'b0;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.mult_en) begin
            w_mul_a_nxt = bus.op_a;
            w_mul_b_nxt = bus.op_b;
            w_uns_nxt   = bus.is_unsign;
            w_cnt_nxt   = CNT_W'(LATENCY - 1);
            w_state_nxt = S_WAIT;
          end else begin
            if (bus.mthi) w_hi_nxt = bus.wdata;
            if (bus.mtlo) w_lo_nxt = bus.wdata;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            w_prod_nxt  = bus.mul_prod;
            w_state_nxt = S_CORR;
          end
        end
        S_CORR: begin
          {w_hi_nxt, w_lo_nxt} = w_corr;
          w_done_nxt           = 1'b1;
          w_state_nxt          = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.mul_a     = r_mul_a;
  assign bus.mul_b     = r_mul_b;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.mult_done = r_done;
  assign bus.mult_busy = w_busy;
endmodule
